// File: rtl/i_divide.sv
// Multi-cycle radix-2 restoring divider for SDIV/UDIV, also returning the remainder.
// One quotient bit per clock; divide-by-zero exits early with ARMv8 results.
module i_divide #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Shifted partial remainder keeps its carry so divisors with the MSB set still work.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
  assign w_sub     = w_rem_sh[WIDTH-1:0] - r_dsr;
  assign w_cnt_nxt = r_cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor skips RUN; FIX publishes the ARMv8 result.
              r_zero  <= 1'b1;
              r_dvd   <= dividend;
              r_state <= S_FIX;
            end else begin
              r_zero  <= 1'b0;
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH);
              r_q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_r_neg <= is_signed & dividend[WIDTH-1];
              busy    <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
          r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt   <= w_cnt_nxt;
          if (w_cnt_nxt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_zero) begin
            quotient    <= '0;
            remainder   <= r_dvd;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= r_q_neg ? -r_dvd : r_dvd;
            remainder   <= r_r_neg ? -r_rem : r_rem;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_divide.sv
// Self-checking bench for i_divide: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_i_divide;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_pass = 0;

  i_divide #(.WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: language-level division with the ARMv8 zero and overflow rules.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                output logic [63:0] q, output logic [63:0] r);
    longint sa;
    longint sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = 64'd0;
      r = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a;
      r = 64'd0;
    end else if (s) begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " quotient"}, quotient, 64'd0);
    chk({tag, " remainder"}, remainder, 64'd0);
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'd0);
  endtask

  // Issue one operation; optionally inject a stray start or a reset at a given cycle.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input int inj_start, input int inj_rst);
    logic [63:0] eq;
    logic [63:0] er;
    int lat;
    int bcnt;
    int extra;
    bit seen;
    model(a, b, s, eq, er);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      if (busy) bcnt++;
      if (lat == inj_start) begin
        start     = 1'b1;
        dividend  = 64'd100;
        divisor   = 64'd10;
        is_signed = 1'b0;
      end
      if (lat == inj_rst) begin
        reset = 1'b0;
        #1;
        check_cleared({tag, " async reset"});
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " no done in reset"}, 64'(done), 64'd0);
        reset = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, " done seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(lat), (b == 64'd0) ? 64'd1 : 64'd65);
    chk({tag, " busy cycles"}, 64'(bcnt), (b == 64'd0) ? 64'd0 : 64'd65);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, 64'(div_by_zero), (b == 64'd0) ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
    chk({tag, " quotient held"}, quotient, eq);
    if (inj_start >= 0) begin
      extra = 0;
      repeat (80) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk({tag, " no second done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 64'd0;
    divisor   = 64'd0;
    #1;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    run_op("u 56/8",        64'd56, 64'd8, 1'b0, -1, -1);
    run_op("s -7/2",        -64'd7, 64'd2, 1'b1, -1, -1);
    run_op("s 7/-2",        64'd7, -64'd2, 1'b1, -1, -1);
    run_op("s -56/8",       -64'd56, 64'd8, 1'b1, -1, -1);
    run_op("div0",          64'h1234, 64'd0, 1'b0, -1, -1);
    run_op("clear dbz",     64'd81, 64'd9, 1'b0, -1, -1);
    run_op("s min/-1",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, -1);
    run_op("u max/2",       64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, -1, -1);
    run_op("u max/max-1",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, -1, -1);
    run_op("s div0 neg",    -64'd5, 64'd0, 1'b1, -1, -1);
    run_op("start busy",    64'd56, 64'd8, 1'b0, 20, -1);
    run_op("reset mid-op",  64'd56, 64'd8, 1'b0, -1, 30);
    run_op("after reset",   64'd81, 64'd9, 1'b0, -1, -1);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom};
        1: rb = 64'($urandom_range(1, 1000));
        2: rb = 64'd0;
        default: rb = {$urandom, $urandom} >> $urandom_range(1, 62);
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, rs, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
